pdu_dma_reader: RTL

- Sits directly downstream of the PDU ring buffer.
- Accepts one DMA descriptor at a time (dma_start, dma_base_addr, dma_size), issues dma_size sequential reads into the buffer, and streams the returned 512-bit flits out on a valid/ready interface framed with sop/eop.
- Pulses dma_done after the last flit is accepted downstream, which releases the buffer's DMA state machine for the next descriptor.
- Credit-based read issue absorbs the fixed buffer read latency under output backpressure.

---
 rtl/pdu_dma_if.sv | 31 +++
 rtl/pdu_dma_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pdu_dma_if.sv
// Bundle of descriptor, buffer-read and output-stream signals for pdu_dma_reader.
// The master modport is the reader's view; slave is the surrounding logic.
interface pdu_dma_if #(
  parameter int AW = 9,
  parameter int DW = 512
);
  logic          dma_start;
  logic [AW-1:0] dma_size;
  logic [AW-1:0] dma_base_addr;
  logic          dma_done;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic          err_overflow;

  modport master (
    input  dma_start, dma_size, dma_base_addr, rd_valid, rd_data, out_ready,
    output dma_done, rd_addr, rd_en, out_data, out_valid, out_sop, out_eop, err_overflow
  );

  modport slave (
    output dma_start, dma_size, dma_base_addr, rd_valid, rd_data, out_ready,
    input  dma_done, rd_addr, rd_en, out_data, out_valid, out_sop, out_eop, err_overflow
  );
endinterface

// File: rtl/pdu_dma_reader.sv
// Reads one descriptor's worth of flits from the PDU ring buffer and streams them
// out with sop/eop framing; read issue is credit-limited by FIFO space.
module pdu_dma_reader #(
  parameter int PDU_DEPTH  = 512,
  parameter int PDU_AWIDTH = $clog2(PDU_DEPTH),
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  pdu_dma_if.master bus
);
  localparam int DW  = 512;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [PDU_AWIDTH-1:0] A_ZERO = {PDU_AWIDTH{1'b0}};
  localparam logic [PDU_AWIDTH-1:0] A_ONE  = PDU_AWIDTH'(1);
  localparam logic [CW-1:0]         C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]         C_ONE  = CW'(1);
  localparam logic [FAW:0]          M_ZERO = {(FAW+1){1'b0}};
  localparam logic [FAW:0]          M_ONE  = (FAW+1)'(1);

  if (FIFO_DEPTH < RD_LAT + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PDU_AWIDTH != $clog2(PDU_DEPTH)) begin : g_cfg_err
    $error("pdu_dma_reader: inconsistent parameters");
  end

  logic [1:0]            state_r, state_nx_s;
  logic [PDU_AWIDTH-1:0] base_r, size_r, issue_cnt_r, ret_cnt_r, rd_addr_r;
  logic [PDU_AWIDTH-1:0] cur_base_s, cur_size_s, cur_issue_s;
  logic [CW-1:0]         inflight_r, fifo_count_s;
  logic [FAW:0]          mem_count_r;
  logic [FAW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [DW+1:0]         mem_r [FIFO_DEPTH];
  logic [DW+1:0]         ret_flit_s;
  logic [DW-1:0]         out_data_r;
  logic rd_en_r, dma_done_r, err_r, out_valid_r, out_sop_r, out_eop_r;
  logic start_ok_s, want_s, credit_ok_s, issue_s, last_issue_s, full_s;
  logic ret_ok_s, dec_s, err_s, out_free_s, mem_rd_s, mem_wr_s, bypass_s;

  assign fifo_count_s = CW'(mem_count_r) + CW'(out_valid_r);
  assign credit_ok_s  = (fifo_count_s + inflight_r) < CW'(FIFO_DEPTH);
  assign full_s       = (fifo_count_s == CW'(FIFO_DEPTH));
  assign start_ok_s   = bus.dma_start && (bus.dma_size != A_ZERO);
  // In IDLE the first read goes out on the same edge that latches the descriptor.
  assign cur_base_s   = (state_r == ST_IDLE) ? bus.dma_base_addr : base_r;
  assign cur_size_s   = (state_r == ST_IDLE) ? bus.dma_size : size_r;
  assign cur_issue_s  = (state_r == ST_IDLE) ? A_ZERO : issue_cnt_r;
  assign want_s       = (state_r == ST_IDLE) ? start_ok_s : (state_r == ST_READ);
  assign issue_s      = want_s && credit_ok_s;
  assign last_issue_s = issue_s && (cur_issue_s == cur_size_s - A_ONE);

  assign dec_s      = bus.rd_valid && (inflight_r != C_ZERO);
  assign ret_ok_s   = dec_s && !full_s;
  assign err_s      = bus.rd_valid && ((inflight_r == C_ZERO) || full_s);
  assign ret_flit_s = {(ret_cnt_r == A_ZERO), (ret_cnt_r == size_r - A_ONE), bus.rd_data};
  assign out_free_s = !out_valid_r || bus.out_ready;
  assign mem_rd_s   = out_free_s && (mem_count_r != M_ZERO);
  assign bypass_s   = out_free_s && (mem_count_r == M_ZERO) && ret_ok_s;
  assign mem_wr_s   = ret_ok_s && !bypass_s;

  // Next-state selection for the transfer FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.dma_start && (bus.dma_size == A_ZERO)) state_nx_s = ST_DONE;
        else if (start_ok_s) state_nx_s = last_issue_s ? ST_DRAIN : ST_READ;
        else state_nx_s = ST_IDLE;
      end
      ST_READ: begin
        if (last_issue_s) state_nx_s = ST_DRAIN;
        else state_nx_s = ST_READ;
      end
      ST_DRAIN: begin
        if (inflight_r == C_ZERO && mem_count_r == M_ZERO && (!out_valid_r || bus.out_ready))
          state_nx_s = ST_DONE;
        else state_nx_s = ST_DRAIN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Control registers: FSM, read issue, credit tracking, return tagging and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      base_r      <= A_ZERO;
      size_r      <= A_ZERO;
      issue_cnt_r <= A_ZERO;
      ret_cnt_r   <= A_ZERO;
      rd_addr_r   <= A_ZERO;
      rd_en_r     <= 1'b0;
      inflight_r  <= C_ZERO;
      dma_done_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      dma_done_r <= (state_nx_s == ST_DONE);
      rd_en_r    <= issue_s;
      if (issue_s) rd_addr_r <= cur_base_s + cur_issue_s;
      if (issue_s) issue_cnt_r <= cur_issue_s + A_ONE;
      else if (state_r == ST_IDLE) issue_cnt_r <= A_ZERO;
      if (state_r == ST_IDLE && bus.dma_start) begin
        base_r    <= bus.dma_base_addr;
        size_r    <= bus.dma_size;
        ret_cnt_r <= A_ZERO;
      end else if (ret_ok_s) begin
        ret_cnt_r <= ret_cnt_r + A_ONE;
      end
      case ({issue_s, dec_s})
        2'b10:   inflight_r <= inflight_r + C_ONE;
        2'b01:   inflight_r <= inflight_r - C_ONE;
        default: inflight_r <= inflight_r;
      endcase
      if (err_s) err_r <= 1'b1;
    end
  end

  // FIFO storage behind the output register.
  always_ff @(posedge clk) begin
    if (mem_wr_s) mem_r[wr_ptr_r] <= ret_flit_s;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {FAW{1'b0}};
      rd_ptr_r    <= {FAW{1'b0}};
      mem_count_r <= M_ZERO;
    end else begin
      if (mem_wr_s) wr_ptr_r <= wr_ptr_r + FAW'(1);
      if (mem_rd_s) rd_ptr_r <= rd_ptr_r + FAW'(1);
      case ({mem_wr_s, mem_rd_s})
        2'b10:   mem_count_r <= mem_count_r + M_ONE;
        2'b01:   mem_count_r <= mem_count_r - M_ONE;
        default: mem_count_r <= mem_count_r;
      endcase
    end
  end

  // Registered first-word-fall-through head; an empty FIFO is bypassed by the return.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
    end else if (out_free_s) begin
      if (mem_rd_s) begin
        {out_sop_r, out_eop_r, out_data_r} <= mem_r[rd_ptr_r];
        out_valid_r <= 1'b1;
      end else if (bypass_s) begin
        {out_sop_r, out_eop_r, out_data_r} <= ret_flit_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.rd_en        = rd_en_r;
  assign bus.rd_addr      = rd_addr_r;
  assign bus.dma_done     = dma_done_r;
  assign bus.err_overflow = err_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_sop      = out_sop_r;
  assign bus.out_eop      = out_eop_r;
endmodule
